// File: rtl/avgpool_pkg.sv
// Shared types and sizing for the avgpool10 global average pooling block.
package avgpool_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CH    = 512;
  localparam int DEF_WOUT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // The sum of WOUT**2 WIDTH-bit samples needs log2(WOUT**2) extra bits.
  function automatic int acc_w(input int width, input int wout);
    return width + $clog2(wout * wout);
  endfunction

endpackage

// File: rtl/avgpool10_if.sv
// Sample-in / pooled-beat-out signal bundle for avgpool10.
interface avgpool10_if #(
  parameter int WIDTH = avgpool_pkg::DEF_WIDTH,
  parameter int CH    = avgpool_pkg::DEF_CH
);
  localparam int ADDR_W = $clog2(CH);

  logic                        layer_en_i;
  logic                        sample_i;
  logic [CH-1:0][WIDTH-1:0]    ofm_i;
  logic [WIDTH-1:0]            out_data_o;
  logic [ADDR_W-1:0]           out_addr_o;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic                        pool_finish_o;
  logic                        sample_drop_o;

  modport master (
    output layer_en_i, sample_i, ofm_i, out_ready_i,
    input  out_data_o, out_addr_o, out_valid_o, pool_finish_o, sample_drop_o
  );

  modport slave (
    input  layer_en_i, sample_i, ofm_i, out_ready_i,
    output out_data_o, out_addr_o, out_valid_o, pool_finish_o, sample_drop_o
  );
endinterface

// File: rtl/avgpool10_lane.sv
// One channel of avgpool10: signed accumulator with clear/add and the pooling shift.
// AVGPOOL10_ROUND_EN selects round-half-up; otherwise the shift truncates toward -inf.
module avgpool10_lane #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 22,
  parameter int SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             add_i,
  input  logic [WIDTH-1:0] ofm_i,
  output logic [WIDTH-1:0] pooled_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    // NOTE: default first so every path assigns acc_d and no latch is inferred.
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'($signed(ofm_i));
    end
  end

  // NOTE: the accumulator is reset like any other register so no stale sum survives rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      // NOTE: non-blocking so every lane and control register samples pre-edge values.
      acc_q <= acc_d;
    end
  end

`ifdef AVGPOOL10_ROUND_EN
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(2 ** (SHIFT - 1));
  logic signed [ACC_W:0] acc_rnd;

  // One extra bit keeps the +half from wrapping a maximal positive sum.
  assign acc_rnd  = (ACC_W + 1)'(acc_q) + HALF;
  assign pooled_o = WIDTH'(acc_rnd >>> SHIFT);
`else
  assign pooled_o = WIDTH'(acc_q >>> SHIFT);
`endif

endmodule

// File: rtl/avgpool10.sv
// avgpool10: averages WOUT x WOUT conv10 samples per channel, then streams CH pooled beats.
// Build option AVGPOOL10_ROUND_EN: round-half-up pooling instead of truncation.
module avgpool10
  import avgpool_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CH    = DEF_CH,
  parameter int WOUT  = DEF_WOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  avgpool10_if.slave bus
);

  localparam int NPIX   = WOUT * WOUT;
  localparam int SHIFT  = $clog2(NPIX);
  localparam int ACC_W  = acc_w(WIDTH, WOUT);
  localparam int ADDR_W = $clog2(CH);

  state_e                  state_q, state_d;
  logic [SHIFT-1:0]        pix_cnt_q, pix_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    drop_q, drop_d;

  logic                    acc_clear, acc_add;
  logic                    last_pix, last_addr, handshake;
  logic [ADDR_W-1:0]       sel;
  logic [WIDTH-1:0]        pooled [CH];

  assign last_pix  = (pix_cnt_q == SHIFT'(NPIX - 1));
  assign last_addr = (out_addr_q == ADDR_W'(CH - 1));
  assign handshake = out_valid_q && bus.out_ready_i;
  assign sel       = (out_valid_q && !last_addr) ? out_addr_q + ADDR_W'(1) : '0;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    avgpool10_lane #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (acc_clear),
      .add_i    (acc_add),
      .ofm_i    (bus.ofm_i[c]),
      .pooled_o (pooled[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.layer_en_i) state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (!bus.layer_en_i)                state_d = ST_IDLE;
        else if (bus.sample_i && last_pix)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.layer_en_i)              state_d = ST_IDLE;
        else if (handshake && last_addr)  state_d = ST_DONE;
      end
      ST_DONE:  if (!bus.layer_en_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_clear   = (state_q == ST_IDLE);
    acc_add     = (state_q == ST_ACCUM) && bus.layer_en_i && bus.sample_i;
    pix_cnt_d   = acc_clear ? '0 : (acc_add ? pix_cnt_q + SHIFT'(1) : pix_cnt_q);
    drop_d      = drop_q || (bus.sample_i && (state_q != ST_ACCUM));
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    if (state_q == ST_DRAIN) begin
      if (!bus.layer_en_i) begin
        out_valid_d = 1'b0;
      end else if (!out_valid_q || (handshake && !last_addr)) begin
        // First DRAIN edge loads channel 0; each later handshake loads the next channel.
        out_valid_d = 1'b1;
        out_addr_d  = sel;
        out_data_d  = pooled[sel];
      end else if (handshake) begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = 1'b0;
    end

    bus.pool_finish_o = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_addr_o    = out_addr_q;
  assign bus.out_data_o    = out_data_q;
  assign bus.sample_drop_o = drop_q;

endmodule
